stream_to_axi4_burst_writer: RTL and testbench
==============================================

STREAM_TO_AXI4_BURST_WRITER -- requirements
Module: stream_to_axi4_burst_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning stream/AXI data width in bits (32, 64 or 128).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning AXI address width.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning maximum beats per burst (power of 2, 2..256).
REQ-004 SHALL have parameter FIFO_DEPTH, default 32, meaning stream buffer depth in beats (power of 2, >= MAX_BURST).
REQ-005 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning 4 KB-aligned start of the destination region.
REQ-006 SHALL have parameter REGION_BYTES, default 4096, meaning destination region size (multiple of 4096).
REQ-007 SHALL have ports, one per line:
clk  in  1  clock; one clock domain
reset_n  in  1  reset, synchronous, active-low
enable  in  1  permit accepting data and launching bursts
s_axis_tdata  in  DATA_W  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tlast  in  1  packet end
s_axis_tready  out  1  stream ready
m_axi_awaddr  out  ADDR_W  burst start address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  log2(DATA_W/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid / m_axi_awready  out / in  1  AW handshake
m_axi_wdata  out  DATA_W  write data
m_axi_wstrb  out  DATA_W/8  all ones
m_axi_wlast  out  1  final beat of burst
m_axi_wvalid / m_axi_wready  out / in  1  W handshake
m_axi_bresp  in  2  write response
m_axi_bvalid / m_axi_bready  in / out  1  B handshake
busy  out  1  state != IDLE or buffer non-empty
err_sticky  out  1  any non-OKAY bresp seen
burst_count  out  16  completed bursts, wraps at 16'hFFFF->0

Function
REQ-008 SHALL buffer stream beats (data + tlast) in a FIFO_DEPTH FIFO; s_axis_tready = enable && !full && !tlast_held.
REQ-009 SHALL set tlast_held on accepting a tlast beat and clear it when that beat completes its W handshake; no further stream beats accepted meanwhile.
REQ-010 SHALL implement states IDLE, AW, W, B; IDLE->AW->W->B->IDLE, AW->W on awready, W->B on wlast handshake, B->IDLE on bvalid.
REQ-011 SHALL compute in IDLE L = min(MAX_BURST, count, beats_to_4KB), beats_to_4KB = (4096 - addr[11:0]) / (DATA_W/8).
REQ-012 SHALL leave IDLE only when enable=1 and count >= min(MAX_BURST, beats_to_4KB), or tlast_held=1 and count>0; awlen latched as L-1 on that edge.
REQ-013 SHALL assert awvalid only in AW, holding awaddr/awlen stable until awready.
REQ-014 SHALL in W drive wvalid = FIFO non-empty, pop on wvalid&&wready, assert wlast on beat L-1 only; no beat dropped or duplicated under any wready pattern.
REQ-015 SHALL assert bready only in B; on bvalid&&bready: set err_sticky if bresp != 2'b00, increment burst_count, advance addr by L*(DATA_W/8).
REQ-016 SHALL wrap addr to BASE_ADDR when the advanced addr equals BASE_ADDR+REGION_BYTES.
REQ-017 SHALL let enable=0 only block new bursts and stream acceptance; an in-flight burst completes.
REQ-018 SHALL continue operating after an error response; err_sticky cleared only by reset.

Reset
REQ-019 SHALL, while reset_n=0 at a clk edge, set state IDLE, FIFO empty, tlast_held 0, addr BASE_ADDR, burst_count 0, err_sticky 0; all valid/ready outputs and busy 0 from that edge on.
REQ-020 SHALL abandon any burst in progress on mid-operation reset; awvalid/wvalid deassert at the reset edge.

Verification
REQ-021 SHALL pass: 16 beats 0..15, no tlast, slave always ready -> one AW addr 8000_0000 awlen 15, W data 0..15, wlast on 16th, burst_count 1, next addr 8000_0040.
REQ-022 SHALL pass: 5-beat packet with tlast -> awlen 4, wlast on 5th beat, tready low from tlast acceptance until 5th W handshake.
REQ-023 SHALL pass: after 1021 beats (63x16 + 13-beat packet) addr 8000_0FF4; push 16 beats -> awlen 2 at 8000_0FF4, then awlen 12 at 8000_0000 (wrap).
REQ-024 SHALL pass: bresp=2'b10 on one burst -> err_sticky 1 and held; following bursts still issued with correct addresses.
REQ-025 SHALL pass: awready low 40 cycles, then wready random 50% -> FIFO fills to 32, tready 0 while full, all data delivered in order.
REQ-026 SHALL pass: reset_n low during beat 7 of a 16-beat W burst -> valids 0 at the reset edge, next burst starts at 8000_0000.

Source files
------------

// File: rtl/stream_to_axi4_burst_writer_if.sv
// rtl/stream_to_axi4_burst_writer_if.sv - stream input and AXI4 write-channel bundle
interface stream_to_axi4_burst_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [DATA_W-1:0]   s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tlast;
  logic                s_axis_tready;

  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_awvalid;
  logic                m_axi_awready;

  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_wvalid;
  logic                m_axi_wready;

  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/stream_to_axi4_burst_writer.sv
// rtl/stream_to_axi4_burst_writer.sv - buffers a stream and writes it as INCR bursts into a wrapping region
module stream_to_axi4_burst_writer #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                MAX_BURST    = 16,
  parameter int                FIFO_DEPTH   = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h8000_0000),
  parameter int                REGION_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  stream_to_axi4_burst_writer_if.master bus,
  output logic        busy,
  output logic        err_sticky,
  output logic [15:0] burst_count
);

  localparam int BYTES    = DATA_W / 8;
  localparam int SIZE_LOG = $clog2(BYTES);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam logic [ADDR_W-1:0] REGION_END = BASE_ADDR + ADDR_W'(REGION_BYTES);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        awlen_r;
  logic [7:0]        beat_cnt;
  logic              awvalid_r;
  logic              in_w;
  logic              bready_r;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              tlast_held;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   head;

  logic [12:0]       bytes_left;
  logic [15:0]       beats_to_4k;
  logic [15:0]       count_x;
  logic [15:0]       thresh;
  logic [15:0]       burst_len;
  logic              launch;
  logic              wlast_int;
  logic [ADDR_W-1:0] adv_addr;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign bus.s_axis_tready = reset_n && enable && !full && !tlast_held;
  assign push = bus.s_axis_tvalid && bus.s_axis_tready;
  assign pop  = bus.m_axi_wvalid && bus.m_axi_wready;

  // Burst length never crosses a 4 KB page and never exceeds what is buffered.
  assign bytes_left  = 13'd4096 - {1'b0, addr[11:0]};
  assign beats_to_4k = 16'(bytes_left >> SIZE_LOG);
  assign count_x     = 16'(count);
  assign thresh      = (16'(MAX_BURST) < beats_to_4k) ? 16'(MAX_BURST) : beats_to_4k;
  assign burst_len   = (count_x < thresh) ? count_x : thresh;
  assign launch      = enable && ((count_x >= thresh) || (tlast_held && count_x != 16'd0));

  assign wlast_int = (beat_cnt == awlen_r);
  assign adv_addr  = addr + ((ADDR_W'(awlen_r) + ADDR_W'(1)) << SIZE_LOG);

  assign bus.m_axi_awaddr  = addr;
  assign bus.m_axi_awlen   = awlen_r;
  assign bus.m_axi_awsize  = 3'(SIZE_LOG);
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awvalid = awvalid_r;
  assign bus.m_axi_wdata   = head[DATA_W-1:0];
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = in_w && wlast_int;
  assign bus.m_axi_wvalid  = in_w && !empty;
  assign bus.m_axi_bready  = bready_r;

  assign busy = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.s_axis_tlast, bus.s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tlast_held <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // Acceptance is blocked while held, so set and clear never coincide.
      if (push && bus.s_axis_tlast) begin
        tlast_held <= 1'b1;
      end else if (pop && head[DATA_W]) begin
        tlast_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr        <= BASE_ADDR;
      awlen_r     <= 8'd0;
      beat_cnt    <= 8'd0;
      awvalid_r   <= 1'b0;
      in_w        <= 1'b0;
      bready_r    <= 1'b0;
      burst_count <= 16'd0;
      err_sticky  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state     <= AW;
            awvalid_r <= 1'b1;
            awlen_r   <= 8'(burst_len - 16'd1);
          end
        end
        AW: begin
          if (bus.m_axi_awready) begin
            state     <= W;
            awvalid_r <= 1'b0;
            in_w      <= 1'b1;
            beat_cnt  <= 8'd0;
          end
        end
        W: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (wlast_int) begin
              state    <= B;
              in_w     <= 1'b0;
              bready_r <= 1'b1;
            end
          end
        end
        B: begin
          if (bus.m_axi_bvalid) begin
            state       <= IDLE;
            bready_r    <= 1'b0;
            burst_count <= burst_count + 16'd1;
            if (bus.m_axi_bresp != 2'b00) begin
              err_sticky <= 1'b1;
            end
            addr <= (adv_addr == REGION_END) ? BASE_ADDR : adv_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_to_axi4_burst_writer.sv
// tb/tb_stream_to_axi4_burst_writer.sv - directed self-checking bench for the stream-to-AXI4 burst writer
module tb_stream_to_axi4_burst_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic        err_sticky;
  logic [15:0] burst_count;

  int checks = 0;
  int fails  = 0;

  logic        aw_stall = 1'b0;
  logic        w_rand = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          b_pending = 0;
  int          w_cnt = 0;
  logic [39:0] aw_q[$];
  logic [32:0] w_q[$];

  stream_to_axi4_burst_writer_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  stream_to_axi4_burst_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .err_sticky  (err_sticky),
    .burst_count (burst_count)
  );

  always #5 clk = ~clk;

  // Handshake monitor: valid&&ready at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      b_pending = 0;
    end else begin
      if (bus.m_axi_awvalid && bus.m_axi_awready) aw_q.push_back({bus.m_axi_awaddr, bus.m_axi_awlen});
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_q.push_back({bus.m_axi_wlast, bus.m_axi_wdata});
        w_cnt++;
        if (bus.m_axi_wlast) b_pending++;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) b_pending--;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.m_axi_awready = !aw_stall;
    bus.m_axi_wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.m_axi_bvalid  = (b_pending > 0);
    bus.m_axi_bresp   = (b_pending > 0) ? bresp_cfg : 2'b00;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_axis_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL push_timeout: beat %0h not accepted, required acceptance within 2000 cycles", d);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((busy || b_pending != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%0b, required 0 within 3000 cycles", name, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.s_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %0b want 0", bus.s_axis_tready); end
    checks++; if (bus.m_axi_awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid: got %0b want 0", bus.m_axi_awvalid); end
    checks++; if (bus.m_axi_wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid: got %0b want 0", bus.m_axi_wvalid); end
    checks++; if (bus.m_axi_bready !== 1'b0) begin fails++; $display("FAIL reset_bready: got %0b want 0", bus.m_axi_bready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", err_sticky); end
    checks++; if (burst_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", burst_count); end
    reset_n = 1'b1;
    enable  = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.s_axis_tready !== 1'b0) begin fails++; $display("FAIL disabled_tready: got %0b want 0", bus.s_axis_tready); end
    enable = 1'b1;
    #1;
    checks++; if (bus.s_axis_tready !== 1'b1) begin fails++; $display("FAIL enabled_tready: got %0b want 1", bus.s_axis_tready); end
    aw_q.delete();
    w_q.delete();
  endtask

  task automatic test_single_burst();
    logic [39:0] aw;
    logic [32:0] w;
    for (int i = 0; i < 16; i++) push(32'(i), 1'b0);
    wait_idle("single");
    checks++; if (aw_q.size() != 1) begin fails++; $display("FAIL single_aw_count: got %0d want 1", aw_q.size()); end
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0000, 8'd15}) begin fails++; $display("FAIL single_aw: got %h want %h", aw, {32'h8000_0000, 8'd15}); end
    checks++; if (w_q.size() != 16) begin fails++; $display("FAIL single_w_count: got %0d want 16", w_q.size()); end
    for (int i = 0; i < 16; i++) begin
      w = (w_q.size() > 0) ? w_q.pop_front() : '1;
      checks++;
      if (w !== {(i == 15), 32'(i)}) begin fails++; $display("FAIL single_w%0d: got %h want %h", i, w, {(i == 15), 32'(i)}); end
    end
    checks++; if (burst_count !== 16'd1) begin fails++; $display("FAIL single_burst_count: got %0d want 1", burst_count); end
  endtask

  task automatic test_packet();
    logic [39:0] aw;
    logic [32:0] w;
    int base;
    int held_bad = 0;
    int n = 0;
    base = w_cnt;
    for (int i = 0; i < 5; i++) push(32'(100 + i), (i == 4));
    while (w_cnt < base + 5 && n < 200) begin
      @(negedge clk);
      #1;
      if (bus.s_axis_tready) held_bad++;
      n++;
    end
    checks++; if (held_bad != 0) begin fails++; $display("FAIL packet_tready_held: got %0d high cycles want 0", held_bad); end
    @(posedge clk);
    #1;
    checks++; if (bus.s_axis_tready !== 1'b1) begin fails++; $display("FAIL packet_tready_release: got %0b want 1", bus.s_axis_tready); end
    wait_idle("packet");
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0040, 8'd4}) begin fails++; $display("FAIL packet_aw: got %h want %h", aw, {32'h8000_0040, 8'd4}); end
    for (int i = 0; i < 5; i++) begin
      w = (w_q.size() > 0) ? w_q.pop_front() : '1;
      checks++;
      if (w !== {(i == 4), 32'(100 + i)}) begin fails++; $display("FAIL packet_w%0d: got %h want %h", i, w, {(i == 4), 32'(100 + i)}); end
    end
    checks++; if (burst_count !== 16'd2) begin fails++; $display("FAIL packet_burst_count: got %0d want 2", burst_count); end
  endtask

  task automatic test_error_response();
    logic [39:0] aw;
    logic [32:0] w;
    bresp_cfg = 2'b10;
    for (int i = 0; i < 16; i++) push(32'(200 + i), 1'b0);
    wait_idle("err1");
    bresp_cfg = 2'b00;
    checks++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL err_set: got %0b want 1", err_sticky); end
    for (int i = 0; i < 16; i++) push(32'(300 + i), 1'b0);
    wait_idle("err2");
    checks++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL err_held: got %0b want 1", err_sticky); end
    checks++; if (burst_count !== 16'd4) begin fails++; $display("FAIL err_burst_count: got %0d want 4", burst_count); end
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0054, 8'd15}) begin fails++; $display("FAIL err_aw1: got %h want %h", aw, {32'h8000_0054, 8'd15}); end
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0094, 8'd15}) begin fails++; $display("FAIL err_aw2: got %h want %h", aw, {32'h8000_0094, 8'd15}); end
    w = (w_q.size() > 0) ? w_q[w_q.size() - 1] : '1;
    checks++; if (w !== {1'b1, 32'd315}) begin fails++; $display("FAIL err_last_w: got %h want %h", w, {1'b1, 32'd315}); end
    w_q.delete();
  endtask

  task automatic test_4kb_boundary();
    logic [39:0] aw;
    logic [32:0] w;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    aw_q.delete();
    w_q.delete();
    checks++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL bnd_err_cleared: got %0b want 0", err_sticky); end
    for (int i = 0; i < 1008; i++) push(32'(i), 1'b0);
    wait_idle("bnd_bulk");
    checks++; if (burst_count !== 16'd63) begin fails++; $display("FAIL bnd_bulk_count: got %0d want 63", burst_count); end
    aw = (aw_q.size() == 63) ? aw_q[62] : '1;
    checks++; if (aw !== {32'h8000_0F80, 8'd15}) begin fails++; $display("FAIL bnd_aw63: got %h want %h", aw, {32'h8000_0F80, 8'd15}); end
    aw_q.delete();
    w_q.delete();
    for (int i = 0; i < 13; i++) push(32'(1008 + i), (i == 12));
    wait_idle("bnd_pkt");
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0FC0, 8'd12}) begin fails++; $display("FAIL bnd_pkt_aw: got %h want %h", aw, {32'h8000_0FC0, 8'd12}); end
    w_q.delete();
    for (int i = 0; i < 16; i++) push(32'(2000 + i), (i == 15));
    wait_idle("bnd_split");
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0FF4, 8'd2}) begin fails++; $display("FAIL bnd_split_aw1: got %h want %h", aw, {32'h8000_0FF4, 8'd2}); end
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0000, 8'd12}) begin fails++; $display("FAIL bnd_split_aw2: got %h want %h", aw, {32'h8000_0000, 8'd12}); end
    for (int i = 0; i < 16; i++) begin
      w = (w_q.size() > 0) ? w_q.pop_front() : '1;
      checks++;
      if (w !== {(i == 2 || i == 15), 32'(2000 + i)}) begin fails++; $display("FAIL bnd_w%0d: got %h want %h", i, w, {(i == 2 || i == 15), 32'(2000 + i)}); end
    end
    checks++; if (burst_count !== 16'd66) begin fails++; $display("FAIL bnd_burst_count: got %0d want 66", burst_count); end
  endtask

  task automatic test_backpressure();
    logic [39:0] aw;
    logic [32:0] w;
    int full_bad = 0;
    aw_stall = 1'b1;
    for (int i = 0; i < 32; i++) push(32'(500 + i), 1'b0);
    bus.s_axis_tdata  = 32'd532;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (bus.s_axis_tready) full_bad++;
    end
    checks++; if (full_bad != 0) begin fails++; $display("FAIL bp_tready_full: got %0d high cycles want 0", full_bad); end
    checks++;
    if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awaddr !== 32'h8000_0034 || bus.m_axi_awlen !== 8'd15) begin
      fails++;
      $display("FAIL bp_aw_hold: got v=%0b a=%h l=%0d want v=1 a=80000034 l=15", bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen);
    end
    aw_stall = 1'b0;
    w_rand   = 1'b1;
    for (int i = 32; i < 48; i++) push(32'(500 + i), 1'b0);
    wait_idle("bp");
    w_rand = 1'b0;
    for (int k = 0; k < 3; k++) begin
      aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
      checks++;
      if (aw !== {32'h8000_0034 + 32'(k * 64), 8'd15}) begin fails++; $display("FAIL bp_aw%0d: got %h want %h", k, aw, {32'h8000_0034 + 32'(k * 64), 8'd15}); end
    end
    checks++; if (w_q.size() != 48) begin fails++; $display("FAIL bp_w_count: got %0d want 48", w_q.size()); end
    for (int i = 0; i < 48; i++) begin
      w = (w_q.size() > 0) ? w_q.pop_front() : '1;
      checks++;
      if (w !== {(i % 16 == 15), 32'(500 + i)}) begin fails++; $display("FAIL bp_w%0d: got %h want %h", i, w, {(i % 16 == 15), 32'(500 + i)}); end
    end
    checks++; if (burst_count !== 16'd69) begin fails++; $display("FAIL bp_burst_count: got %0d want 69", burst_count); end
  endtask

  task automatic test_mid_reset();
    logic [39:0] aw;
    logic [32:0] w;
    int base;
    int n = 0;
    base = w_cnt;
    for (int i = 0; i < 16; i++) push(32'(700 + i), 1'b0);
    while (w_cnt < base + 6 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (bus.m_axi_wvalid !== 1'b1) begin fails++; $display("FAIL mid_wvalid_before: got %0b want 1", bus.m_axi_wvalid); end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b0 || bus.m_axi_bready !== 1'b0 || bus.s_axis_tready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_valids: got aw=%0b w=%0b b=%0b t=%0b busy=%0b want all 0",
               bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.s_axis_tready, busy);
    end
    checks++; if (w_cnt != base + 6) begin fails++; $display("FAIL mid_beats_done: got %0d want %0d", w_cnt - base, 6); end
    checks++; if (burst_count !== 16'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", burst_count); end
    reset_n = 1'b1;
    aw_q.delete();
    w_q.delete();
    for (int i = 0; i < 16; i++) push(32'(800 + i), 1'b0);
    wait_idle("mid");
    aw = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
    checks++; if (aw !== {32'h8000_0000, 8'd15}) begin fails++; $display("FAIL mid_aw: got %h want %h", aw, {32'h8000_0000, 8'd15}); end
    w = (w_q.size() > 0) ? w_q[0] : '1;
    checks++; if (w !== {1'b0, 32'd800}) begin fails++; $display("FAIL mid_first_w: got %h want %h", w, {1'b0, 32'd800}); end
    checks++; if (w_q.size() != 16) begin fails++; $display("FAIL mid_w_count: got %0d want 16", w_q.size()); end
    checks++; if (burst_count !== 16'd1) begin fails++; $display("FAIL mid_burst_count: got %0d want 1", burst_count); end
  endtask

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    test_reset();
    test_single_burst();
    test_packet();
    test_error_response();
    test_4kb_boundary();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
